// File: rtl/if_fetch.sv
// Instruction-fetch stage: IDLE/FETCH/HOLD sequencer feeding the IF/ID register.
// Optional feature macro: IF_FETCH_PERF_COUNT_EN enables the delivered-instruction counter.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  logic [31:0] w_pc_inc;
  logic [31:0] w_target;

  assign w_pc_inc = r_pc + 32'd4;
  assign w_target = {redirect_pc[31:2], 2'b00};

  // Outputs are combinational so a ready word reaches IF/ID in the same cycle.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = r_pc;
    pc_plus4    = 32'h0000_0000;
    instr       = 32'h0000_0000;
    ifid_enable = 1'b0;
    ifid_flush  = 1'b0;
    case (r_state)
      IDLE: begin
        imem_req = 1'b0;
      end
      FETCH: begin
        imem_req = 1'b1;
        pc_plus4 = w_pc_inc;
        if (redirect) begin
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
        end else if (imem_ready && !stall) begin
          ifid_enable = 1'b1;
          instr       = imem_rdata;
        end else if (imem_ready) begin
          ifid_enable = 1'b0;
        end else begin
          ifid_enable = !stall;
          ifid_flush  = !stall;
        end
      end
      HOLD: begin
        instr    = r_hold;
        pc_plus4 = w_pc_inc;
        if (redirect) begin
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
        end else if (stall) begin
          ifid_enable = 1'b0;
        end else begin
          ifid_enable = 1'b1;
        end
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Sequencer: redirect outranks stall and memory readiness in FETCH and HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_hold  <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            r_pc <= w_target;
          end else if (imem_ready && !stall) begin
            r_pc <= w_pc_inc;
          end else if (imem_ready) begin
            r_hold  <= imem_rdata;
            r_state <= HOLD;
          end else begin
            r_pc <= r_pc;
          end
        end
        HOLD: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_hold  <= 32'h0000_0000;
            r_state <= FETCH;
          end else if (!stall) begin
            r_pc    <= w_pc_inc;
            r_state <= FETCH;
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef IF_FETCH_PERF_COUNT_EN
  logic [31:0] r_fetch_count;

  // Counts real deliveries only; bubbles and stalls do not advance it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 32'h0000_0000;
    end else if (ifid_enable && !ifid_flush) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 32'h0000_0000;
`endif

endmodule
